// File: rtl/uart_rx_bit_sampler_pkg.sv
// Shared UART RX definitions: prescale and bit-count widths, the legal
// oversampling ratios, the frame length and small helpers used by the RX datapath.
package uart_rx_bit_sampler_pkg;

    localparam int PRESC_W  = 6;
    localparam int BITCNT_W = 4;

    typedef logic [PRESC_W-1:0]  presc_t;
    typedef logic [BITCNT_W-1:0] bitcnt_t;

    localparam presc_t PRESC_8  = 6'd8;
    localparam presc_t PRESC_16 = 6'd16;
    localparam presc_t PRESC_32 = 6'd32;

    // Start + 8 data + parity + stop; the RX FSM compares BitCnt against this.
    localparam int FRAME_BITS = 11;

    // Map any requested ratio onto a supported one; unsupported values fall back to 8.
    function automatic presc_t legal_prescale(input presc_t req);
        case (req)
            PRESC_16: return PRESC_16;
            PRESC_32: return PRESC_32;
            default:  return PRESC_8;
        endcase
    endfunction

    // Two-out-of-three vote over the mid-bit samples.
    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous RX line. Flops reset to the
// idle-high level so the FSM never sees a false start bit coming out of reset.
module uart_rx_sync
    import uart_rx_bit_sampler_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    // Shift the raw line through the flop chain, idle-high under reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// UART RX bit sampler: synchronises RX_IN, runs the oversample edge counter and
// the completed-bit counter, captures three mid-bit samples and majority-votes them.
module uart_rx_bit_sampler
    import uart_rx_bit_sampler_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_BITCNT  = 15
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RX_IN,
    input  logic [PRESC_W-1:0]  Prescale,
    input  logic                CntEnable,
    output logic [PRESC_W-1:0]  EdgeCnt,
    output logic [BITCNT_W-1:0] BitCnt,
    output logic                BitDone,
    output logic                SampledBit,
    output logic                SampleValid,
    output logic                RxSync
);

    localparam bitcnt_t BITCNT_MAX = bitcnt_t'(MAX_BITCNT);

    logic       en_q;
    logic       en_rise;
    presc_t     presc_q;
    presc_t     presc_eff;
    presc_t     half;
    logic       at_last;
    logic       at_s0;
    logic       at_s1;
    logic       at_s2;
    logic [2:0] samp_q;
    logic [2:0] samp_next;

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (RX_IN),
        .q   (RxSync)
    );

    // The first counting cycle already needs the new ratio, so bypass the latch on the rising edge.
    assign en_rise   = CntEnable & ~en_q;
    assign presc_eff = en_rise ? legal_prescale(Prescale) : presc_q;
    assign half      = {1'b0, presc_eff[PRESC_W-1:1]};

    assign at_last = (EdgeCnt == presc_eff - 6'd1);
    assign at_s0   = (EdgeCnt == half - 6'd2);
    assign at_s1   = (EdgeCnt == half - 6'd1);
    assign at_s2   = (EdgeCnt == half);

    assign BitDone = CntEnable & at_last;

    // Track CntEnable and freeze the prescale ratio for the whole enabled window.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            en_q    <= 1'b0;
            presc_q <= PRESC_8;
        end else begin
            en_q <= CntEnable;
            if (en_rise) begin
                presc_q <= legal_prescale(Prescale);
            end
        end
    end

    // Oversample edge counter and saturating completed-bit counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            EdgeCnt <= '0;
            BitCnt  <= '0;
        end else if (!CntEnable) begin
            EdgeCnt <= '0;
            BitCnt  <= '0;
        end else if (at_last) begin
            EdgeCnt <= '0;
            if (BitCnt != BITCNT_MAX) begin
                BitCnt <= BitCnt + bitcnt_t'(1);
            end
        end else begin
            EdgeCnt <= EdgeCnt + 6'd1;
        end
    end

    // Next value of the three mid-bit sample registers.
    always_comb begin
        samp_next = samp_q;
        if (!CntEnable) begin
            samp_next = 3'b111;
        end else begin
            if (at_s0) samp_next[0] = RxSync;
            if (at_s1) samp_next[1] = RxSync;
            if (at_s2) samp_next[2] = RxSync;
        end
    end

    // Store samples and publish the voted bit with a one-cycle strobe after the last sample.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_q      <= 3'b111;
            SampledBit  <= 1'b1;
            SampleValid <= 1'b0;
        end else begin
            samp_q      <= samp_next;
            SampleValid <= CntEnable & at_s2;
            if (CntEnable && at_s2) begin
                SampledBit <= majority3(samp_next);
            end
        end
    end

endmodule
